// File: rtl/serial_in_queue_if.sv
// rtl/serial_in_queue_if.sv - producer handshake and CPU load/store bus for the serial input queue
interface serial_in_queue_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [31:0] address;
    logic [31:0] data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] cpu_rd_data;
    logic        QueueAddress;
    logic        QueueInterrupt;

    modport master (
        output in_valid, in_data, address, data, MemRead, MemWrite,
        input  in_ready, cpu_rd_data, QueueAddress, QueueInterrupt
    );

    modport slave (
        input  in_valid, in_data, address, data, MemRead, MemWrite,
        output in_ready, cpu_rd_data, QueueAddress, QueueInterrupt
    );
endinterface

// File: rtl/serial_in_queue.sv
// rtl/serial_in_queue.sv - memory-mapped byte FIFO input device with pending/overflow interrupt
module serial_in_queue #(
    parameter int          DEPTH       = 8,
    parameter logic [31:0] DATA_ADDR   = 32'hffff0070,
    parameter logic [31:0] STATUS_ADDR = 32'hffff0074,
    parameter logic [31:0] ACK_ADDR    = 32'hffff0078
) (
    input logic              clk,
    input logic              reset,
    serial_in_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    fifo [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          pending;
    logic          overflow;

    logic hit_data;
    logic hit_status;
    logic hit_ack;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic drop;
    logic ack;

    assign hit_data   = (bus.address == DATA_ADDR);
    assign hit_status = (bus.address == STATUS_ADDR);
    assign hit_ack    = (bus.address == ACK_ADDR);

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Acceptance depends only on the registered count, so a same-cycle pop never frees a slot early.
    assign bus.in_ready = !full;
    assign push = bus.in_valid && !full;
    assign drop = bus.in_valid && full;
    assign pop  = bus.MemRead && hit_data && !empty;
    assign ack  = bus.MemWrite && hit_ack;

    assign bus.QueueAddress   = hit_data || hit_status || hit_ack;
    assign bus.QueueInterrupt = pending;

    // Load data mux: head byte, status word, or zero for anything else.
    always_comb begin
        bus.cpu_rd_data = 32'b0;
        if (hit_data && !empty) begin
            bus.cpu_rd_data = {24'b0, fifo[head]};
        end else if (hit_status) begin
            bus.cpu_rd_data = {pending, 15'b0, 8'(count), 5'b0, overflow, full, empty};
        end
    end

    // Byte storage; contents need no reset because reads are gated by count.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo[tail] <= bus.in_data;
        end
    end

    // Pointers, occupancy and flags; sets beat a simultaneous ack, reset beats everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            pending  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (push) begin
                pending <= 1'b1;
            end else if (ack) begin
                pending <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ack) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_in_queue.sv
// tb/tb_serial_in_queue.sv - scoreboard bench for serial_in_queue
module tb_serial_in_queue;
    localparam logic [31:0] DATA_A   = 32'hffff0070;
    localparam logic [31:0] STATUS_A = 32'hffff0074;
    localparam logic [31:0] ACK_A    = 32'hffff0078;

    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;
    logic [7:0] sb [$];

    serial_in_queue_if bus ();

    serial_in_queue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.address  = 32'h0;
        bus.data     = 32'h0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
    endtask

    task automatic status_is(input string tag, input logic [31:0] exp);
        bus.address = STATUS_A;
        bus.MemRead = 1'b1;
        #1;
        check(tag, bus.cpu_rd_data, exp);
        bus.MemRead = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accepted);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        if (accepted) sb.push_back(b);
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_byte(input string tag);
        logic [31:0] exp;
        exp = 32'h0;
        if (sb.size() > 0) exp = {24'b0, sb.pop_front()};
        bus.address = DATA_A;
        bus.MemRead = 1'b1;
        #1;
        check(tag, bus.cpu_rd_data, exp);
        cyc();
        bus.MemRead = 1'b0;
    endtask

    task automatic ack_write();
        bus.address  = ACK_A;
        bus.data     = 32'hdeadbeef;
        bus.MemWrite = 1'b1;
        cyc();
        bus.MemWrite = 1'b0;
    endtask

    initial begin
        logic [31:0] addrs [6];
        logic        hits  [6];
        addrs = '{32'hffff0070, 32'hffff0074, 32'hffff0078, 32'hffff006c, 32'h10010000, 32'hffff007c};
        hits  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        idle();
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        #1;

        // reset / idle state
        check("rst_ready", 32'(bus.in_ready), 32'h1);
        check("rst_irq", 32'(bus.QueueInterrupt), 32'h0);
        status_is("rst_status", 32'h00000001);
        pop_byte("empty_read");
        status_is("empty_read_status", 32'h00000001);

        // two bytes, drain, ack
        push_byte(8'h41, 1'b1);
        push_byte(8'h42, 1'b1);
        check("two_irq", 32'(bus.QueueInterrupt), 32'h1);
        status_is("two_status", 32'h80000200);
        pop_byte("pop_41");
        pop_byte("pop_42");
        status_is("drained_status", 32'h80000001);
        ack_write();
        status_is("ack_status", 32'h00000001);
        check("ack_irq", 32'(bus.QueueInterrupt), 32'h0);

        // fill, overflow, drain
        for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i), 1'b1);
        check("full_ready", 32'(bus.in_ready), 32'h0);
        status_is("full_status", 32'h80000802);
        push_byte(8'hff, 1'b0);
        status_is("ovf_status", 32'h80000806);
        for (int i = 0; i < 8; i++) pop_byte("drain_full");
        status_is("drain_status", 32'h80000005);
        bus.address = ACK_A;
        bus.MemRead = 1'b1;
        #1;
        check("ack_load", bus.cpu_rd_data, 32'h0);
        bus.MemRead = 1'b0;
        ack_write();
        status_is("ack2_status", 32'h00000001);

        // full: push + pop same cycle, push rejected
        for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i), 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h99;
        bus.address  = DATA_A;
        bus.MemRead  = 1'b1;
        #1;
        check("full_pushpop_data", bus.cpu_rd_data, {24'b0, sb.pop_front()});
        cyc();
        idle();
        status_is("full_pushpop_status", 32'h80000704);
        for (int i = 0; i < 4; i++) pop_byte("down_to_3");
        status_is("count3_status", 32'h80000304);

        // push + pop together at count 3 across pointer wrap
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h30 + 8'(i);
            bus.address  = DATA_A;
            bus.MemRead  = 1'b1;
            #1;
            check("wrap_pushpop", bus.cpu_rd_data, {24'b0, sb.pop_front()});
            sb.push_back(8'h30 + 8'(i));
            cyc();
            idle();
            status_is("wrap_count", 32'h80000304);
        end
        for (int i = 0; i < 3; i++) pop_byte("wrap_drain");
        ack_write();

        // ack concurrent with push, then reset with bytes queued
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        bus.address  = ACK_A;
        bus.MemWrite = 1'b1;
        sb.push_back(8'h55);
        cyc();
        idle();
        check("ack_push_irq", 32'(bus.QueueInterrupt), 32'h1);
        status_is("ack_push_status", 32'h80000100);
        for (int i = 0; i < 4; i++) push_byte(8'h60 + 8'(i), 1'b1);
        status_is("five_status", 32'h80000500);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        sb.delete();
        status_is("reset_mid_status", 32'h00000001);
        check("reset_mid_irq", 32'(bus.QueueInterrupt), 32'h0);
        check("reset_mid_ready", 32'(bus.in_ready), 32'h1);

        // address decode, and a miss load does not pop
        for (int i = 0; i < 6; i++) begin
            bus.address = addrs[i];
            #1;
            check("queue_address", 32'(bus.QueueAddress), 32'(hits[i]));
        end
        push_byte(8'h77, 1'b1);
        bus.address = 32'hffff006c;
        bus.MemRead = 1'b1;
        #1;
        check("miss_load_data", bus.cpu_rd_data, 32'h0);
        cyc();
        bus.MemRead = 1'b0;
        status_is("miss_load_status", 32'h80000100);
        pop_byte("pop_77");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
